operand_entry: RTL and testbench
================================

Name: operand_entry

Overview:
- Front end of the ALU datapath; produces the 10-bit operands bus that the adder/display operation blocks consume.
- An operator enters two 5-bit sign-magnitude operands on slide switches, one at a time, confirming each with an Enter push-button.
- Debounces the buttons, sequences left-then-right capture, and presents {left,right} with a valid/ack handshake.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable samples needed before a button level is accepted (range 2..2^20).
- OP_WIDTH, 5, width of one operand; the operands bus is 2*OP_WIDTH.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- switches  input  OP_WIDTH  raw slide switches; bit 4 is the sign, bits 3:0 the magnitude.
- enter_btn  input  1  raw Enter button, active-high, may bounce.
- clear_btn  input  1  raw Clear button, active-high, may bounce.
- operands_ack  input  1  consumer accepts the presented pair.
- operands  output  2*OP_WIDTH  {left[4:0], right[4:0]}; left occupies bits 9:5.
- operands_valid  output  1  pair complete and stable.
- stage  output  2  current FSM state, for the status display.

Behaviour:
- Reset values: operands=0, operands_valid=0, stage=S_LEFT, debounce counters=0, debounced levels=0.
- Input sync: enter_btn and clear_btn each pass through a 2-flop synchronizer before debounce. switches are sampled directly at capture time; the operator holds them static.
- Debounce: the accepted level changes only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing sample resets that button's counter to 0.
- Edge: a press is one cycle on a 0->1 transition of the accepted level. Holding the button produces no repeat. Release needs its own debounce before the next press counts.
- Press latency: (2 sync + DEBOUNCE_CYCLES + 1) cycles from a clean raw edge to the FSM action.
- FSM states: S_LEFT=0, S_RIGHT=1, S_HOLD=2. Encoding 3 is illegal and returns to S_LEFT next cycle.
- S_LEFT, enter press: left <- switches, go to S_RIGHT.
- S_RIGHT, enter press: right <- switches, go to S_HOLD. operands_valid rises on the cycle after the press.
- S_HOLD:
  - operands_valid=1 and operands held constant.
  - Enter presses are ignored.
  - operands_ack=1: clear valid next cycle, go to S_LEFT. operands keeps its last value.
- operands_ack outside S_HOLD is ignored.
- Clear press in any state: go to S_LEFT, clear operands_valid, zero both operands. Clear has priority over enter and ack in the same cycle.
- Enter and clear presses in the same cycle: clear wins, nothing is captured.
- Partial state: in S_RIGHT, operands[9:5] shows the captured left and [4:0] shows 0. The operands bus is meaningful to the consumer only while valid=1.
- Asynchronous reset mid-entry discards the partial operand.
- No arithmetic is performed; values are stored bit-exact.

Optional Feature:
- SIGN_MAG_NORMALIZE_EN defined: a captured operand equal to 5'b10000 (negative zero) is stored as 5'b00000. Applies to both left and right.
- Undefined: 5'b10000 is stored unchanged.
- Either way, latency and handshake are identical.

Decomposition:
- Package operand_entry_pkg:
  - OP_WIDTH_DEFAULT=5.
  - state typedef/localparams S_LEFT, S_RIGHT, S_HOLD (2-bit).
  - NEG_ZERO=5'b10000.
- One sub-module: button_debouncer, containing synchronizer, counter, accepted level and rise pulse, parameterised by DEBOUNCE_CYCLES. Instantiated twice (enter, clear).

Test Plan (DEBOUNCE_CYCLES=4):
- Reset asserted mid-S_RIGHT -> immediately operands=0, valid=0, stage=0. Once reset is released, stays idle until a press.
- switches=5'b00101, press enter; then switches=5'b10011, press enter -> operands=10'b00101_10011 and valid=1 exactly 7 cycles after the second clean raw edge, stage=2. Ack -> valid=0 next cycle, stage=0.
- Enter bounces 1,0,1,0 at 1-cycle spacing, then stays high for 10 cycles -> exactly one capture. The bounce alone (pulses shorter than 4 cycles) causes no capture.
- In S_HOLD: an enter press plus switch changes -> operands unchanged, valid stays 1. Ack in S_LEFT -> no effect.
- Clear and enter presses debounced to the same cycle in S_RIGHT -> stage=0, operands=0, no capture. Clear during S_HOLD -> valid=0 next cycle.
- Capture of 5'b10000 as left -> operands[9:5]=00000 with SIGN_MAG_NORMALIZE_EN, 10000 without.

Source files
------------

// File: rtl/operand_entry_pkg.sv
// Shared types and constants for the operand entry front end.
package operand_entry_pkg;

  localparam int unsigned OP_WIDTH_DEFAULT = 5;
  localparam logic [4:0]  NEG_ZERO         = 5'b10000;

  typedef enum logic [1:0] {
    S_LEFT  = 2'd0,
    S_RIGHT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/operand_entry_button_debouncer.sv
// Two-flop synchronizer plus counter debouncer; emits a one-cycle pulse when
// the accepted level rises.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Captures left then right sign-magnitude operands on debounced Enter presses
// and presents {left,right} with a valid/ack handshake. Optional macro:
// SIGN_MAG_NORMALIZE_EN stores negative zero as positive zero.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned OP_WIDTH        = OP_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OP_WIDTH-1:0]   switches,
  input  logic                  enter_btn,
  input  logic                  clear_btn,
  input  logic                  operands_ack,
  output logic [2*OP_WIDTH-1:0] operands,
  output logic                  operands_valid,
  output logic [1:0]            stage
);

  state_t                state, state_nxt;
  logic [OP_WIDTH-1:0]   left_q, right_q, left_nxt, right_nxt;
  logic                  valid_nxt;
  logic                  enter_press, clear_press;

`ifdef SIGN_MAG_NORMALIZE_EN
  localparam logic [OP_WIDTH-1:0] NEG_ZERO_W = (OP_WIDTH == OP_WIDTH_DEFAULT) ?
    OP_WIDTH'(NEG_ZERO) : {1'b1, {(OP_WIDTH-1){1'b0}}};
`endif

  function automatic logic [OP_WIDTH-1:0] norm(input logic [OP_WIDTH-1:0] v);
`ifdef SIGN_MAG_NORMALIZE_EN
    norm = (v == NEG_ZERO_W) ? '0 : v;
`else
    norm = v;
`endif
  endfunction

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk   (clk),
    .reset (reset),
    .raw   (enter_btn),
    .press (enter_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk   (clk),
    .reset (reset),
    .raw   (clear_btn),
    .press (clear_press)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_LEFT;
      left_q         <= '0;
      right_q        <= '0;
      operands_valid <= 1'b0;
    end else begin
      state          <= state_nxt;
      left_q         <= left_nxt;
      right_q        <= right_nxt;
      operands_valid <= valid_nxt;
    end
  end

  // Clear outranks enter and ack; the unused encoding falls back to S_LEFT
  always_comb begin
    state_nxt = state;
    left_nxt  = left_q;
    right_nxt = right_q;
    valid_nxt = operands_valid;
    if (clear_press) begin
      state_nxt = S_LEFT;
      left_nxt  = '0;
      right_nxt = '0;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        S_LEFT: begin
          if (enter_press) begin
            left_nxt  = norm(switches);
            right_nxt = '0;
            state_nxt = S_RIGHT;
          end
        end
        S_RIGHT: begin
          if (enter_press) begin
            right_nxt = norm(switches);
            valid_nxt = 1'b1;
            state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (operands_ack) begin
            valid_nxt = 1'b0;
            state_nxt = S_LEFT;
          end
        end
        default: begin
          valid_nxt = 1'b0;
          state_nxt = S_LEFT;
        end
      endcase
    end
  end

  assign operands = {left_q, right_q};
  assign stage    = state;

endmodule

// File: tb/tb_operand_entry.sv
// Directed scoreboard bench for operand_entry with DEBOUNCE_CYCLES=4.
module tb_operand_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] switches;
  logic       enter_btn;
  logic       clear_btn;
  logic       operands_ack;
  logic [9:0] operands;
  logic       operands_valid;
  logic [1:0] stage;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_pair;
  logic [4:0] nz_exp;

  operand_entry #(.DEBOUNCE_CYCLES(4), .OP_WIDTH(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .switches       (switches),
    .enter_btn      (enter_btn),
    .clear_btn      (clear_btn),
    .operands_ack   (operands_ack),
    .operands       (operands),
    .operands_valid (operands_valid),
    .stage          (stage)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold raw buttons for 'hold' cycles, then release and let release debounce
  task automatic press(input logic en, input logic cl, input int hold);
    enter_btn = en;
    clear_btn = cl;
    cyc(hold);
    enter_btn = 1'b0;
    clear_btn = 1'b0;
    cyc(10);
  endtask

  task automatic pop_chk(input string tag);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed empty-queue expected entry", tag);
    end else begin
      exp_pair = exp_q.pop_front();
      checks--;
      chk(tag, 32'(operands), 32'(exp_pair));
    end
  endtask

  initial begin
    reset = 1'b1;
    switches = '0;
    enter_btn = 1'b0;
    clear_btn = 1'b0;
    operands_ack = 1'b0;
    cyc(3);
    chk("rst_operands", 32'(operands), 32'h0);
    chk("rst_valid", 32'(operands_valid), 32'h0);
    chk("rst_stage", 32'(stage), 32'h0);
    reset = 1'b0;
    cyc(10);
    chk("idle_stage", 32'(stage), 32'h0);

    // left capture
    switches = 5'b00101;
    press(1'b1, 1'b0, 8);
    chk("left_stage", 32'(stage), 32'h1);
    chk("left_partial", 32'(operands), 32'({5'b00101, 5'b00000}));
    chk("left_valid", 32'(operands_valid), 32'h0);

    // right capture with exact latency of 2+4+1 cycles
    switches = 5'b10011;
    exp_q.push_back({5'b00101, 5'b10011});
    enter_btn = 1'b1;
    cyc(6);
    chk("lat_early_valid", 32'(operands_valid), 32'h0);
    cyc(1);
    chk("lat_valid", 32'(operands_valid), 32'h1);
    chk("hold_stage", 32'(stage), 32'h2);
    pop_chk("pair1");
    cyc(3);
    enter_btn = 1'b0;
    cyc(10);

    // enter press and switch change in S_HOLD ignored
    switches = 5'b11111;
    press(1'b1, 1'b0, 8);
    chk("hold_ign_ops", 32'(operands), 32'({5'b00101, 5'b10011}));
    chk("hold_ign_valid", 32'(operands_valid), 32'h1);
    chk("hold_ign_stage", 32'(stage), 32'h2);

    // ack
    operands_ack = 1'b1;
    cyc(1);
    operands_ack = 1'b0;
    chk("ack_valid", 32'(operands_valid), 32'h0);
    chk("ack_stage", 32'(stage), 32'h0);
    chk("ack_ops_kept", 32'(operands), 32'({5'b00101, 5'b10011}));

    // ack in S_LEFT ignored
    operands_ack = 1'b1;
    cyc(2);
    operands_ack = 1'b0;
    chk("ack_left_stage", 32'(stage), 32'h0);
    chk("ack_left_valid", 32'(operands_valid), 32'h0);

    // bounce alone does not capture
    switches = 5'b01010;
    for (int i = 0; i < 4; i++) begin
      enter_btn = (i % 2 == 0);
      cyc(1);
    end
    cyc(8);
    chk("bounce_only_stage", 32'(stage), 32'h0);

    // bounce then steady high: exactly one capture
    for (int i = 0; i < 4; i++) begin
      enter_btn = (i % 2 == 0);
      cyc(1);
    end
    press(1'b1, 1'b0, 10);
    chk("bounce_stage", 32'(stage), 32'h1);
    chk("bounce_left", 32'(operands), 32'({5'b01010, 5'b00000}));

    // asynchronous reset mid S_RIGHT
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_ops", 32'(operands), 32'h0);
    chk("async_rst_valid", 32'(operands_valid), 32'h0);
    chk("async_rst_stage", 32'(stage), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(10);
    chk("post_rst_stage", 32'(stage), 32'h0);
    chk("post_rst_ops", 32'(operands), 32'h0);

    // clear and enter same cycle in S_RIGHT
    switches = 5'b00111;
    press(1'b1, 1'b0, 8);
    chk("pre_clr_stage", 32'(stage), 32'h1);
    switches = 5'b01001;
    press(1'b1, 1'b1, 8);
    chk("clr_ent_stage", 32'(stage), 32'h0);
    chk("clr_ent_ops", 32'(operands), 32'h0);
    chk("clr_ent_valid", 32'(operands_valid), 32'h0);

    // clear during S_HOLD
    switches = 5'b00001;
    press(1'b1, 1'b0, 8);
    switches = 5'b00010;
    exp_q.push_back({5'b00001, 5'b00010});
    press(1'b1, 1'b0, 8);
    chk("hold2_valid", 32'(operands_valid), 32'h1);
    pop_chk("pair2");
    clear_btn = 1'b1;
    cyc(6);
    chk("clr_hold_early", 32'(operands_valid), 32'h1);
    cyc(1);
    chk("clr_hold_valid", 32'(operands_valid), 32'h0);
    chk("clr_hold_stage", 32'(stage), 32'h0);
    chk("clr_hold_ops", 32'(operands), 32'h0);
    cyc(3);
    clear_btn = 1'b0;
    cyc(10);

    // negative zero as left operand
`ifdef SIGN_MAG_NORMALIZE_EN
    nz_exp = 5'b00000;
`else
    nz_exp = 5'b10000;
`endif
    switches = 5'b10000;
    press(1'b1, 1'b0, 8);
    chk("negzero_stage", 32'(stage), 32'h1);
    chk("negzero_left", 32'(operands), 32'({nz_exp, 5'b00000}));

    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
